// File: rtl/stim_check_pkg.sv
// Shared types and LFSR helpers for the on-chip equivalence harness.
package stim_check_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RSTHOLD,
      ST_GAP,
      ST_RUN,
      ST_DONE
   } state_e;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   // Galois right-shift step: feedback taps are XORed in when the bit shifted out is 1
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/stim_check_harness_if.sv
// Bundle between the harness, the two DUT copies and the run controller.
interface stim_check_harness_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              start;
   logic              dut_rst;
   logic [DATA_W-1:0] stim;
   logic [DATA_W-1:0] golden_out;
   logic [DATA_W-1:0] netlist_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [CNT_W-1:0]  mismatch_cnt;
   logic [CNT_W-1:0]  vec_idx;
   logic              fail_valid;
   logic [CNT_W-1:0]  first_fail_idx;
   logic [DATA_W-1:0] first_fail_golden;
   logic [DATA_W-1:0] first_fail_netlist;

   modport master (
      input  start, golden_out, netlist_out,
      output dut_rst, stim, busy, done, pass, mismatch_cnt, vec_idx,
             fail_valid, first_fail_idx, first_fail_golden, first_fail_netlist
   );

   modport slave (
      output start, golden_out, netlist_out,
      input  dut_rst, stim, busy, done, pass, mismatch_cnt, vec_idx,
             fail_valid, first_fail_idx, first_fail_golden, first_fail_netlist
   );
endinterface

// File: rtl/stim_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load and single-step advance.
module stim_lfsr
   import stim_check_pkg::*;
#(
   parameter logic [31:0] RESET_SEED = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] state
);

   logic [31:0] state_q;
   logic [31:0] state_d;

   // An all-zero state would lock up, so a zero seed becomes 1
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == 32'h0) ? 32'h1 : seed;
      end else if (step) begin
         state_d = lfsr_next(state_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= (RESET_SEED == 32'h0) ? 32'h1 : RESET_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

endmodule

// File: rtl/stim_check_harness.sv
// Drives reset and pseudo-random vectors into golden/netlist copies and
// compares their outputs after a settle interval, keeping the first failure.
module stim_check_harness
   import stim_check_pkg::*;
#(
   parameter int          DATA_W        = 32,
   parameter int          NUM_VECTORS   = 1000,
   parameter int          RESET_CYCLES  = 2,
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [31:0] LFSR_SEED     = 32'h0000_0001,
   parameter int          CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   stim_check_harness_if.master bus
);

   localparam logic [31:0]      SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_e            state_q, state_d;
   logic [15:0]       rst_cnt_q, rst_cnt_d;
   logic [15:0]       settle_cnt_q, settle_cnt_d;
   logic [CNT_W-1:0]  vec_idx_q, vec_idx_d;
   logic [DATA_W-1:0] stim_q, stim_d;
   logic              dut_rst_q, dut_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
   logic              fail_valid_q, fail_valid_d;
   logic [CNT_W-1:0]  ff_idx_q, ff_idx_d;
   logic [DATA_W-1:0] ff_golden_q, ff_golden_d;
   logic [DATA_W-1:0] ff_netlist_q, ff_netlist_d;

   logic              lfsr_load;
   logic              lfsr_step;
   logic [31:0]       lfsr_state;
   logic [31:0]       lfsr_nxt;
   logic              compare_en;
   logic              start_ok;

   stim_lfsr #(
      .RESET_SEED (SEED_EFF)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (SEED_EFF),
      .state (lfsr_state)
   );

   always_comb begin
      state_d        = state_q;
      rst_cnt_d      = rst_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      vec_idx_d      = vec_idx_q;
      stim_d         = stim_q;
      dut_rst_d      = dut_rst_q;
      mismatch_cnt_d = mismatch_cnt_q;
      fail_valid_d   = fail_valid_q;
      ff_idx_d       = ff_idx_q;
      ff_golden_d    = ff_golden_q;
      ff_netlist_d   = ff_netlist_q;
      lfsr_load      = 1'b0;
      lfsr_step      = 1'b0;
      compare_en     = 1'b0;
      lfsr_nxt       = lfsr_next(lfsr_state);
      // A restart from DONE waits for the done flag so start is never taken while busy reads 1
      start_ok       = bus.start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && done_q));

      case (state_q)
         ST_IDLE: begin
            dut_rst_d = 1'b1;
            stim_d    = '0;
         end
         ST_RSTHOLD: begin
            if (32'(rst_cnt_q) >= RESET_CYCLES - 1) begin
               compare_en = 1'b1;
               dut_rst_d  = 1'b0;
               state_d    = ST_GAP;
            end else begin
               rst_cnt_d = rst_cnt_q + 16'd1;
            end
         end
         ST_GAP: begin
            if (NUM_VECTORS == 0) begin
               state_d = ST_DONE;
            end else begin
               lfsr_step    = 1'b1;
               stim_d       = lfsr_nxt[DATA_W-1:0];
               vec_idx_d    = CNT_W'(1);
               settle_cnt_d = '0;
               state_d      = ST_RUN;
            end
         end
         ST_RUN: begin
            if (32'(settle_cnt_q) >= SETTLE_CYCLES - 1) begin
               compare_en   = 1'b1;
               settle_cnt_d = '0;
               if (32'(vec_idx_q) < NUM_VECTORS) begin
                  lfsr_step = 1'b1;
                  stim_d    = lfsr_nxt[DATA_W-1:0];
                  vec_idx_d = vec_idx_q + CNT_W'(1);
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               settle_cnt_d = settle_cnt_q + 16'd1;
            end
         end
         ST_DONE: begin
         end
         default: state_d = ST_IDLE;
      endcase

      if (compare_en && (bus.golden_out != bus.netlist_out)) begin
         if (mismatch_cnt_q != CNT_MAX) begin
            mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
         end
         if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            ff_idx_d     = vec_idx_q;
            ff_golden_d  = bus.golden_out;
            ff_netlist_d = bus.netlist_out;
         end
      end

      if (start_ok) begin
         state_d        = ST_RSTHOLD;
         rst_cnt_d      = '0;
         settle_cnt_d   = '0;
         vec_idx_d      = '0;
         dut_rst_d      = 1'b1;
         stim_d         = '0;
         mismatch_cnt_d = '0;
         fail_valid_d   = 1'b0;
         ff_idx_d       = '0;
         ff_golden_d    = '0;
         ff_netlist_d   = '0;
         lfsr_load      = 1'b1;
      end

      // done/pass follow one cycle after entering DONE so pass sees the final count
      done_d = start_ok ? 1'b0 : (done_q || (state_q == ST_DONE));
      pass_d = start_ok ? 1'b0 : ((state_q == ST_DONE) ? (mismatch_cnt_q == '0) : pass_q);
      busy_d = (state_d != ST_IDLE) && !done_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         rst_cnt_q      <= '0;
         settle_cnt_q   <= '0;
         vec_idx_q      <= '0;
         stim_q         <= '0;
         dut_rst_q      <= 1'b1;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         mismatch_cnt_q <= '0;
         fail_valid_q   <= 1'b0;
         ff_idx_q       <= '0;
         ff_golden_q    <= '0;
         ff_netlist_q   <= '0;
      end else begin
         state_q        <= state_d;
         rst_cnt_q      <= rst_cnt_d;
         settle_cnt_q   <= settle_cnt_d;
         vec_idx_q      <= vec_idx_d;
         stim_q         <= stim_d;
         dut_rst_q      <= dut_rst_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         pass_q         <= pass_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         fail_valid_q   <= fail_valid_d;
         ff_idx_q       <= ff_idx_d;
         ff_golden_q    <= ff_golden_d;
         ff_netlist_q   <= ff_netlist_d;
      end
   end

   assign bus.dut_rst            = dut_rst_q;
   assign bus.stim               = stim_q;
   assign bus.busy               = busy_q;
   assign bus.done               = done_q;
   assign bus.pass               = pass_q;
   assign bus.mismatch_cnt       = mismatch_cnt_q;
   assign bus.vec_idx            = vec_idx_q;
   assign bus.fail_valid         = fail_valid_q;
   assign bus.first_fail_idx     = ff_idx_q;
   assign bus.first_fail_golden  = ff_golden_q;
   assign bus.first_fail_netlist = ff_netlist_q;

endmodule

// File: doc/stim_check_harness.md
Name: stim_check_harness

Overview:
- Synthesizable, on-chip version of the post-route equivalence check.
- Drives a shared reset and a pseudo-random input vector into a golden design and its post-route netlist.
- Compares the two designs' outputs at a fixed settle interval and counts mismatches.
- Records the first failure and reports pass/fail, so equivalence runs on the fabric without a simulator.

Parameters:
- DATA_W, 32: width of the stimulus vector and of each compared output.
- NUM_VECTORS, 1000: number of random vectors applied after reset.
- RESET_CYCLES, 2: cycles dut_rst is held high.
- SETTLE_CYCLES, 2: cycles between applying a vector and sampling the outputs (minimum 1).
- LFSR_SEED, 32'h0000_0001: initial LFSR state. A value of 0 is replaced by 1.
- CNT_W, 16: width of mismatch_cnt and of the vector indices.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- dut_rst  out  1  active-high reset to both DUT copies.
- stim  out  DATA_W  input vector to both DUT copies.
- golden_out  in  DATA_W  golden design output.
- netlist_out  in  DATA_W  netlist output.
- busy  out  1  run in progress.
- done  out  1  sticky; run finished.
- pass  out  1  valid when done; 1 if mismatch_cnt==0.
- mismatch_cnt  out  CNT_W  saturating mismatch count.
- vec_idx  out  CNT_W  index of the vector currently applied.
- fail_valid  out  1  a first failure has been captured.
- first_fail_idx  out  CNT_W  vector index of the first mismatch.
- first_fail_golden  out  DATA_W  golden_out at the first mismatch.
- first_fail_netlist  out  DATA_W  netlist_out at the first mismatch.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - dut_rst=1 and stim=0.
  - busy, done, pass and fail_valid are 0; all counters and capture registers are 0.
  - The LFSR is loaded with LFSR_SEED.
- All outputs are registered.
- FSM states: IDLE, RSTHOLD, GAP, RUN, DONE.
- IDLE:
  - dut_rst=1 and stim=0.
  - When start=1, go to RSTHOLD. On that transition, clear mismatch_cnt, fail_valid, done and pass, and reload the LFSR with LFSR_SEED.
- RSTHOLD:
  - Lasts RESET_CYCLES cycles with dut_rst=1 and stim=0.
  - On the last cycle, perform compare #0 (reset-state check, vec_idx=0).
  - Then deassert dut_rst and go to GAP.
- GAP:
  - Lasts one cycle with dut_rst=0 and stim=0.
  - On exit, advance the LFSR one step, load stim with the new LFSR value, set vec_idx=1, and go to RUN.
- RUN:
  - Each vector is held for exactly SETTLE_CYCLES cycles.
  - On the last cycle of a vector, compare golden_out with netlist_out.
  - On that same edge, if vec_idx<NUM_VECTORS: advance the LFSR, load stim with the new value, and increment vec_idx.
  - Otherwise, go to DONE.
- DONE:
  - done=1 and busy=0; pass=(mismatch_cnt==0).
  - stim and dut_rst hold their last values.
  - start returns to RSTHOLD, which begins a new run.
- busy=1 in RSTHOLD, GAP and RUN.
- Timing: done rises 1+RESET_CYCLES+1+NUM_VECTORS*SETTLE_CYCLES cycles after start is sampled. With default parameters this is 2004 cycles.
- Compare rules:
  - A mismatch is any bit difference (!=).
  - mismatch_cnt increments by 1 per mismatching compare and saturates at all-ones.
  - On the first mismatch of a run, capture the index and both output values and set fail_valid. Later mismatches do not overwrite the capture.
- LFSR:
  - 32-bit Galois, right-shifting, tap mask 32'h8020_0003.
  - Step rule: if lsb=1, next=(s>>1)^mask; otherwise next=s>>1.
  - stim is the low DATA_W bits of the LFSR state.
  - With seed 1, vector 1 = 32'h8020_0003 and vector 2 = 32'hC030_0002.
- Boundary and corner cases:
  - start while busy is ignored.
  - An asynchronous reset mid-run aborts the run. dut_rst is reasserted immediately, and the harness does not restart until a new start.
  - A compare and a vector load on the same edge use pre-edge values of golden_out and netlist_out.
  - NUM_VECTORS=0 goes from GAP straight to DONE, with only compare #0 performed.

Decomposition:
- Package stim_check_pkg contains:
  - the FSM state enum;
  - the LFSR_TAPS constant;
  - a lfsr_next function.
- Sub-module: stim_lfsr. It takes load, step and seed inputs and provides a state output.

Test Plan:
- netlist_out tied to golden_out, defaults → done at 2004 cycles after start, pass=1, mismatch_cnt=0, fail_valid=0.
- netlist_out=golden_out^1 always → mismatch_cnt=1001, first_fail_idx=0, pass=0.
- Fault injected only while vec_idx==5 → mismatch_cnt=1, first_fail_idx=5, first_fail_golden/first_fail_netlist equal the injected pair.
- Seed 1 → stim sequence observed as 0, then 32'h8020_0003, then 32'hC030_0002 on successive vector loads; dut_rst high for exactly 2 cycles after start.
- start pulsed mid-run → ignored, timing unchanged. rst pulled low at vec_idx=300 → busy=0, dut_rst=1, counters 0. A fresh start then yields a full passing run.
- CNT_W=4 with an always-mismatching netlist → mismatch_cnt saturates at 15.
